// File: rtl/execute_mul_pipe.sv
// Three-stage pipelined signed 32x32 multiplier feeding writeback over a valid/ready handshake.
// The whole pipe stalls on backpressure; flush kills every in-flight op.
module execute_mul_pipe #(
    parameter int ROB_W = 4,
    parameter int FID_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_src0_value,
    input  logic [31:0]      i_src1_value,
    input  logic [ROB_W-1:0] i_dst_rob,
    input  logic [FID_W-1:0] i_fid,
    input  logic             i_mul_cmd,
    output logic             o_valid,
    input  logic             i_wb_ready,
    output logic [31:0]      o_result,
    output logic [ROB_W-1:0] o_dst_rob,
    output logic [FID_W-1:0] o_fid
);

    logic adv_s;
    logic accept_s;

    logic s1_valid_r;
    logic s2_valid_r;
    logic s3_valid_r;

    logic signed [16:0] a_lo_s;
    logic signed [16:0] b_lo_s;
    logic signed [15:0] a_hi_s;
    logic signed [15:0] b_hi_s;
    logic        [31:0] ll_s;
    logic signed [32:0] lh_s;
    logic signed [32:0] hl_s;
    logic signed [31:0] hh_s;

    logic        [31:0] s1_ll_r;
    logic signed [32:0] s1_lh_r;
    logic signed [32:0] s1_hl_r;
    logic signed [31:0] s1_hh_r;
    logic [ROB_W-1:0]   s1_rob_r;
    logic [FID_W-1:0]   s1_fid_r;
    logic               s1_cmd_r;

    logic signed [33:0] mid_s;
    logic        [63:0] mid_ext_s;
    logic        [63:0] prod_s;

    logic [63:0]        s2_prod_r;
    logic [ROB_W-1:0]   s2_rob_r;
    logic [FID_W-1:0]   s2_fid_r;
    logic               s2_cmd_r;

    logic [31:0]        sel_s;
    logic [31:0]        s3_result_r;
    logic [ROB_W-1:0]   s3_rob_r;
    logic [FID_W-1:0]   s3_fid_r;

    assign adv_s    = ~s3_valid_r | i_wb_ready;
    assign accept_s = i_valid & adv_s & ~i_flush;

    // Split operands into 16-bit halves and form the four partial products.
    always_comb begin
        a_lo_s = $signed({1'b0, i_src0_value[15:0]});
        b_lo_s = $signed({1'b0, i_src1_value[15:0]});
        a_hi_s = $signed(i_src0_value[31:16]);
        b_hi_s = $signed(i_src1_value[31:16]);
        ll_s   = {16'd0, i_src0_value[15:0]} * {16'd0, i_src1_value[15:0]};
        lh_s   = 33'(a_lo_s) * 33'(b_hi_s);
        hl_s   = 33'(a_hi_s) * 33'(b_lo_s);
        hh_s   = 32'(a_hi_s) * 32'(b_hi_s);
    end

    // Recombine partial products into the full 64-bit signed product.
    always_comb begin
        mid_s     = 34'(s1_lh_r) + 34'(s1_hl_r);
        mid_ext_s = 64'(mid_s);
        prod_s    = {s1_hh_r, 32'd0} + (mid_ext_s << 16) + {32'd0, s1_ll_r};
    end

    // Pick the requested product half for the final stage.
    always_comb begin
        sel_s = 32'd0;
        if (s2_cmd_r) begin
            sel_s = s2_prod_r[63:32];
        end else begin
            sel_s = s2_prod_r[31:0];
        end
    end

    // Valid bits: flush beats advance, stall holds everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
        end else if (i_flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= accept_s;
            s2_valid_r <= s1_valid_r;
            s3_valid_r <= s2_valid_r;
        end
    end

    // Datapath and tag registers shift with the valid bits and are left unreset.
    always_ff @(posedge clk) begin
        if (adv_s) begin
            s1_ll_r     <= ll_s;
            s1_lh_r     <= lh_s;
            s1_hl_r     <= hl_s;
            s1_hh_r     <= hh_s;
            s1_rob_r    <= i_dst_rob;
            s1_fid_r    <= i_fid;
            s1_cmd_r    <= i_mul_cmd;
            s2_prod_r   <= prod_s;
            s2_rob_r    <= s1_rob_r;
            s2_fid_r    <= s1_fid_r;
            s2_cmd_r    <= s1_cmd_r;
            s3_result_r <= sel_s;
            s3_rob_r    <= s2_rob_r;
            s3_fid_r    <= s2_fid_r;
        end
    end

    assign o_ready   = adv_s;
    assign o_valid   = s3_valid_r;
    assign o_result  = s3_result_r;
    assign o_dst_rob = s3_rob_r;
    assign o_fid     = s3_fid_r;

endmodule

// File: tb/tb_execute_mul_pipe.sv
// Scoreboard bench for execute_mul_pipe: directed vectors push expected results,
// an independent monitor pops and compares on every writeback handshake.
module tb_execute_mul_pipe;

    logic        clk;
    logic        resetn;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_src0_value;
    logic [31:0] i_src1_value;
    logic [3:0]  i_dst_rob;
    logic [7:0]  i_fid;
    logic        i_mul_cmd;
    logic        o_valid;
    logic        i_wb_ready;
    logic [31:0] o_result;
    logic [3:0]  o_dst_rob;
    logic [7:0]  o_fid;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rob;
        logic [7:0]  fid;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   cyc;

    // corner vectors: a, b, cmd, hand-computed expected result
    localparam int NV = 12;
    logic [31:0] va[NV] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0000FFFF, 32'h0000FFFF,
                            32'hFFFF0000, 32'hFFFF0000, 32'h00010000, 32'h00012345};
    logic [31:0] vb[NV] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0000FFFF, 32'h0000FFFF,
                            32'h00008000, 32'h00008000, 32'h00010000, 32'h00000010};
    logic        vc[NV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ve[NV] = '{32'h40000000, 32'h00000000, 32'h00000001, 32'h00000000,
                            32'h3FFFFFFF, 32'h00000001, 32'hFFFE0001, 32'h00000000,
                            32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h00123450};
    logic [31:0] bp_exp[4] = '{32'd3003, 32'd3006, 32'd3009, 32'd3012};

    execute_mul_pipe #(.ROB_W(4), .FID_W(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_src0_value (i_src0_value),
        .i_src1_value (i_src1_value),
        .i_dst_rob    (i_dst_rob),
        .i_fid        (i_fid),
        .i_mul_cmd    (i_mul_cmd),
        .o_valid      (o_valid),
        .i_wb_ready   (i_wb_ready),
        .o_result     (o_result),
        .o_dst_rob    (o_dst_rob),
        .o_fid        (o_fid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Present one op and hold it until accepted; push the expected response on acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [3:0] r, input logic [7:0] f,
                         input logic [31:0] exp_res, input bit chk_lat);
        int tries;
        bit done;
        tries = 0;
        done  = 1'b0;
        i_valid      = 1'b1;
        i_src0_value = a;
        i_src1_value = b;
        i_mul_cmd    = c;
        i_dst_rob    = r;
        i_fid        = f;
        while (!done) begin
            @(negedge clk);
            if (o_ready && !i_flush) begin
                sb.push_back('{exp_res, r, f, chk_lat ? cyc + 3 : -1});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries > 50) begin
                total++;
                bad++;
                $display("FAIL issue_timeout: fid %h never accepted", f);
                done = 1'b1;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || o_valid) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sb.size() != 0 || o_valid) begin
            bad++;
            $display("FAIL drain: %0d results still pending, o_valid %b", sb.size(), o_valid);
        end
    endtask

    task automatic expect_idle(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(name, {31'd0, o_valid}, 32'd0);
        end
    endtask

    // Monitor: every handshake must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && o_valid && i_wb_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got result %h rob %h fid %h with nothing expected",
                             o_result, o_dst_rob, o_fid);
                end else begin
                    e = sb.pop_front();
                    if (o_result !== e.res || o_dst_rob !== e.rob || o_fid !== e.fid ||
                        (e.lat >= 0 && e.lat != cyc)) begin
                        bad++;
                        $display("FAIL wb_result: got res %h rob %h fid %h cycle %0d, expected res %h rob %h fid %h cycle %0d",
                                 o_result, o_dst_rob, o_fid, cyc, e.res, e.rob, e.fid, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        resetn       = 1'b0;
        i_flush      = 1'b0;
        i_valid      = 1'b0;
        i_src0_value = 32'd0;
        i_src1_value = 32'd0;
        i_dst_rob    = 4'd0;
        i_fid        = 8'd0;
        i_mul_cmd    = 1'b0;
        i_wb_ready   = 1'b1;
        #2;
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_ready", {31'd0, o_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // basic latency, both halves
        issue(32'd7, 32'hFFFFFFFD, 1'b0, 4'd5, 8'h21, 32'hFFFFFFEB, 1'b1);
        issue(32'd7, 32'hFFFFFFFD, 1'b1, 4'd6, 8'h22, 32'hFFFFFFFF, 1'b1);

        // corner operands back to back
        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], vc[i], 4'(i), 8'(8'h40 + i), ve[i], 1'b1);
        end
        wait_drain();

        // four ops with backpressure while the first result sits in s3
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    issue(32'(1000 + i), 32'd3, 1'b0, 4'(i), 8'(i), bp_exp[i-1], 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                i_wb_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_ready", {31'd0, o_ready}, 32'd0);
                    check("bp_valid", {31'd0, o_valid}, 32'd1);
                    check("bp_hold", o_result, 32'd3003);
                end
                @(posedge clk);
                #1;
                i_wb_ready = 1'b1;
            end
        join
        wait_drain();

        // flush with three ops in flight, s3 stalled, and a new op presented
        i_wb_ready = 1'b0;
        issue(32'd5, 32'd5, 1'b0, 4'd1, 8'h51, 32'd25, 1'b0);
        issue(32'd6, 32'd6, 1'b0, 4'd2, 8'h52, 32'd36, 1'b0);
        issue(32'd7, 32'd7, 1'b0, 4'd3, 8'h53, 32'd49, 1'b0);
        i_flush      = 1'b1;
        i_valid      = 1'b1;
        i_src0_value = 32'd8;
        i_src1_value = 32'd8;
        i_fid        = 8'h54;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_stall_valid", {31'd0, o_valid}, 32'd0);
        check("flush_stall_ready", {31'd0, o_ready}, 32'd1);
        i_wb_ready = 1'b1;
        expect_idle("flush_idle", 4);

        // flush on an empty pipe blocks the op presented with it
        @(posedge clk);
        #1;
        i_flush      = 1'b1;
        i_valid      = 1'b1;
        i_src0_value = 32'd9;
        i_src1_value = 32'd9;
        i_fid        = 8'h55;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        expect_idle("flush_block", 4);
        @(posedge clk);
        #1;
        issue(32'h7FFFFFFF, 32'd2, 1'b0, 4'd9, 8'h56, 32'hFFFFFFFE, 1'b1);
        wait_drain();

        // asynchronous reset with three ops in flight
        issue(32'd11, 32'd11, 1'b0, 4'd1, 8'h61, 32'd121, 1'b0);
        issue(32'd12, 32'd12, 1'b0, 4'd2, 8'h62, 32'd144, 1'b0);
        issue(32'd13, 32'd13, 1'b0, 4'd3, 8'h63, 32'd169, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, o_valid}, 32'd0);
        check("async_rst_ready", {31'd0, o_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        expect_idle("post_rst_idle", 4);
        @(posedge clk);
        #1;
        issue(32'h00000100, 32'hFFFFFF00, 1'b0, 4'd7, 8'h64, 32'hFFFF0000, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_mul_pipe.md
Name: execute_mul_pipe

Overview:
- Three-stage pipelined 32x32 multiplier.
- Sits directly downstream of the multiply-issue input register stage.
- Consumes that stage's valid, src0/src1 values, destination ROB index, fid and mul_cmd.
- Produces a 32-bit result toward writeback using a valid/ready handshake, with full-pipeline stall on backpressure and a flush that kills all in-flight operations.

Parameters:
ROB_W, 4, width of destination ROB index
FID_W, 8, width of fetch/flow id tag

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  reset; asynchronous, active-low
i_flush  input  1  kill all in-flight and incoming ops
i_valid  input  1  operation present from input register stage
o_ready  output  1  pipeline can accept this cycle
i_src0_value  input  32  multiplicand (signed)
i_src1_value  input  32  multiplier (signed)
i_dst_rob  input  ROB_W  destination ROB entry
i_fid  input  FID_W  tag, carried unchanged
i_mul_cmd  input  1  0 = low 32 bits of product, 1 = high 32 bits (signed MULH)
o_valid  output  1  result valid to writeback
i_wb_ready  input  1  writeback accepts result this cycle
o_result  output  32  selected product half
o_dst_rob  output  ROB_W  ROB tag of result
o_fid  output  FID_W  fid of result

Behaviour:
- Reset: resetn low asynchronously clears s1/s2/s3 valid bits, so o_valid=0 immediately. Data/tag registers are not reset. o_result/o_dst_rob/o_fid are don't-care while o_valid=0. Reset mid-operation discards all in-flight ops.
- Advance signal: adv = ~s3_valid | i_wb_ready.
- o_ready = adv (combinational, no dependence on i_valid).
- Accept: i_valid & adv & ~i_flush. i_valid while o_ready=0 is ignored; upstream must hold.
- Stall: when adv=0, all three stages hold all registers, valid bits included.
- Advance: when adv=1, the whole pipeline shifts one stage:
  - s1_valid <= accept
  - s2_valid <= s1_valid
  - s3_valid <= s2_valid
- Latency: op accepted at edge N appears with o_valid=1 after edge N+3, provided no stall intervenes.
- Throughput: 1 op/cycle.
- Handshake: a result is consumed at an edge where o_valid & i_wb_ready. o_result/o_dst_rob/o_fid must stay stable while o_valid=1 and i_wb_ready=0.
- Flush: i_flush=1 at an edge clears s1/s2/s3 valid bits, including during a stall, and blocks acceptance of the input that cycle. Flush has priority over advance and stall.
- Arithmetic:
  - P = signed(src0) * signed(src1), 64 bits.
  - Split each operand: aL/bL = bits[15:0] zero-extended; aH/bH = bits[31:16] signed.
  - S1 registers four partial products: LL = aL*bL (32b unsigned), LH = aL*bH, HL = aH*bL, HH = aH*bH (signed). S1 also registers rob, fid and cmd.
  - S2 registers P = HH<<32 + (LH+HL)<<16 + LL, all sign-extended to 64 bits.
  - S3 registers result = cmd ? P[63:32] : P[31:0], plus rob and fid.
- Tags: dst_rob, fid and mul_cmd travel with their op; no reordering.

Test Plan:
- Basic latency: src0=7, src1=-3 (0xFFFFFFFD), cmd=0, rob=5, fid=0x21, wb_ready=1 -> o_valid exactly 3 cycles after accept, o_result=0xFFFFFFEB, o_dst_rob=5, o_fid=0x21. Same operands with cmd=1 -> 0xFFFFFFFF.
- Corner operands:
  - 0x80000000*0x80000000: cmd=1 -> 0x40000000; cmd=0 -> 0x00000000.
  - 0xFFFFFFFF*0xFFFFFFFF: cmd=0 -> 0x00000001; cmd=1 -> 0x00000000.
  - 0x7FFFFFFF*0x7FFFFFFF: cmd=1 -> 0x3FFFFFFF; cmd=0 -> 0x00000001.
- Back-to-back with backpressure: 4 consecutive ops with fid 1..4. Hold i_wb_ready=0 from cycle 3 for 5 cycles -> o_ready=0 while s3 is full and stalled. o_result stays stable. After release, results emerge in order 1,2,3,4 with none lost or duplicated.
- Flush: 3 ops in flight, assert i_flush one cycle together with a new i_valid -> o_valid stays 0 for all 4 ops. The next op accepted after flush emerges 3 cycles later with correct result.
- Flush during stall: s3_valid=1, i_wb_ready=0, i_flush=1 -> o_valid=0 next cycle, o_ready=1.
- Async reset mid-operation: assert resetn=0 between clock edges with 3 ops in flight -> o_valid drops immediately without a clock edge. After release, no stale results appear and a new op completes with latency 3.
